fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 9 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_BURST = 4;
  localparam int STATS_W   = 16;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_owner, wrapping.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] pick
);
  always_comb begin : pick_b
    logic          found;
    logic [IW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_owner) + k) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter muxing NREQ requesters onto one FIFO write port, up to BURST words per grant.
// Define FIFO_WR_ARBITER_STATS_EN to add per-requester 16-bit transfer counters on port stats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int BURST = DEF_BURST
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_we,
  output logic [WIDTH-1:0]        fifo_din,
  output logic                    fifo_cs,
  output logic [NREQ-1:0]         grant,
  output logic                    busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NREQ*STATS_W-1:0] stats
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  state_t            state, state_nx;
  logic [NREQ-1:0]   grant_nx, pick;
  logic [CW-1:0]     cnt, cnt_nx, cnt_inc;
  logic [IW-1:0]     last_owner, last_nx, owner;
  logic              owner_valid;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .pick       (pick)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) owner = IW'(i);
  end

  // grant is all-zero outside GRANT, so ready/we/din fall to zero when idle or in reset
  assign owner_valid = |(req_valid & grant);
  assign req_ready   = grant & {NREQ{~fifo_full}};
  assign fifo_we     = |(req_valid & req_ready);
  assign busy        = (state == GRANT);
  assign cnt_inc     = cnt + CW'(1);

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++)
      fifo_din = fifo_din | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    cnt_nx   = cnt;
    last_nx  = last_owner;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nx = GRANT;
          grant_nx = pick;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        // a dropped valid releases even when full holds off the transfer
        if (!owner_valid) begin
          state_nx = IDLE;
          grant_nx = '0;
          last_nx  = owner;
        end else if (fifo_we) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == CW'(BURST)) begin
            state_nx = IDLE;
            grant_nx = '0;
            last_nx  = owner;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      cnt        <= '0;
      last_owner <= IW'(NREQ - 1);
      fifo_cs    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      cnt        <= cnt_nx;
      last_owner <= last_nx;
      fifo_cs    <= 1'b1;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NREQ-1:0][STATS_W-1:0] stat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] & req_ready[i]) stat_q[i] <= stat_q[i] + STATS_W'(1);
    end
  end

  assign stats = stat_q;
`endif
endmodule
